hs_rx_fifo: RTL and testbench

HS_RX_FIFO -- requirements
Module: hs_rx_fifo

---
 rtl/hs_rx_fifo.sv | 117 +++++++++++
 tb/tb_hs_rx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_rx_fifo.sv
// Receives words over a 4-phase req/ack handshake from an async sender into a show-ahead FIFO.
// Latency: req to write/ack/out_valid is three clk_receiver edges (two-flop sync plus FSM edge).
// Backpressure: when full, ack is withheld and the word stays with the sender until a slot frees.
module hs_rx_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk_receiver,
    input  logic              rst_n,
    input  logic              data_req,
    input  logic [DATA_W-1:0] data_driver,
    output logic              data_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     fifo_cnt,
    output logic [7:0]        xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic              req_ff1;
    logic              req_ff2;
    logic              req_s;
    logic              push;
    logic              pop;
    logic              full;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req_s     = req_ff2;
    assign full      = (fifo_cnt == FULL_CNT);
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    // data_req comes from another clock domain; only the second stage feeds control.
    always_ff @(posedge clk_receiver or negedge rst_n) begin
        if (!rst_n) begin
            req_ff1 <= 1'b0;
            req_ff2 <= 1'b0;
        end else begin
            req_ff1 <= data_req;
            req_ff2 <= req_ff1;
        end
    end

    always_ff @(posedge clk_receiver or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            data_ack <= (state_nxt == ACK);
        end
    end

    // Full uses registered occupancy, so a pop this edge cannot open space for a push this edge.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && !full) begin
                    push      = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_receiver or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            xfer_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                xfer_cnt <= xfer_cnt + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk_receiver) begin
        if (push) begin
            mem[wr_ptr] <= data_driver;
        end
    end

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Directed and randomized handshake traffic checked against a queue-based model of the receiver FIFO.
module tb_hs_rx_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              data_req = 1'b0;
    logic [DATA_W-1:0] data_driver = '0;
    logic              out_ready = 1'b0;
    logic              data_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        fifo_cnt;
    logic [7:0]        xfer_cnt;

    int                checks = 0;
    int                failures = 0;
    logic [DATA_W-1:0] q[$];
    logic [7:0]        xfer_m = 8'd0;
    logic [DATA_W-1:0] cur_word = '0;
    bit                rnd = 1'b0;
    int                max_cnt = 0;

    hs_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_receiver(clk),
        .rst_n(rst_n),
        .data_req(data_req),
        .data_driver(data_driver),
        .data_ack(data_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .fifo_cnt(fifo_cnt),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: pop/push decided from the model, then occupancy and counters compared.
    task automatic tick();
        bit   do_pop;
        int   pre_size;
        logic prev_ack;
        pre_size = q.size();
        do_pop   = (pre_size != 0) && (out_ready === 1'b1);
        if (do_pop) check("out_data", out_data, q[0]);
        prev_ack = data_ack;
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (data_ack === 1'b1 && prev_ack === 1'b0) begin
            check("push_space", pre_size < DEPTH, 1);
            q.push_back(cur_word);
            xfer_m = xfer_m + 8'd1;
        end
        if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
        check("fifo_cnt", fifo_cnt, q.size());
        check("out_valid", out_valid, q.size() != 0);
        check("xfer_cnt", xfer_cnt, xfer_m);
    endtask

    task automatic wait_ack(input logic lvl, input int budget);
        int n;
        n = 0;
        while (data_ack !== lvl && n < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("ack_wait", data_ack, lvl);
    endtask

    task automatic hs(input logic [DATA_W-1:0] v);
        data_driver = v;
        cur_word    = v;
        data_req    = 1'b1;
        wait_ack(1'b1, 80);
        data_req = 1'b0;
        wait_ack(1'b0, 20);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        tick();
        check("drain_empty", fifo_cnt, 0);
    endtask

    initial begin
        #3;
        check("rst_ack", data_ack, 0);
        check("rst_valid", out_valid, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_xfer", xfer_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word, exact three-edge latency
        data_driver = 4'hA;
        cur_word    = 4'hA;
        data_req    = 1'b1;
        tick();
        check("lat_e1_ack", data_ack, 0);
        tick();
        check("lat_e2_ack", data_ack, 0);
        tick();
        check("lat_e3_ack", data_ack, 1);
        check("lat_e3_valid", out_valid, 1);
        check("lat_e3_data", out_data, 4'hA);
        check("lat_e3_cnt", fifo_cnt, 1);
        check("lat_e3_xfer", xfer_cnt, 1);
        data_req = 1'b0;
        tick();
        tick();
        tick();
        check("ack_release", data_ack, 0);
        drain();

        // Fill to DEPTH, fifth word held off until one pop
        for (int i = 1; i <= 4; i++) hs(4'(i));
        check("fill_cnt", fifo_cnt, 4);
        data_driver = 4'h5;
        cur_word    = 4'h5;
        data_req    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("full_noack", data_ack, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_noack", data_ack, 0);
        wait_ack(1'b1, 10);
        check("full_refill_cnt", fifo_cnt, 4);
        data_req = 1'b0;
        wait_ack(1'b0, 10);
        drain();

        // Held request gives exactly one write
        data_driver = 4'h7;
        cur_word    = 4'h7;
        data_req    = 1'b1;
        wait_ack(1'b1, 10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("held_ack", data_ack, 1);
        end
        check("held_cnt", fifo_cnt, 1);
        data_req = 1'b0;
        wait_ack(1'b0, 10);
        check("held_cnt_after", fifo_cnt, 1);
        drain();

        // Push and pop on the same edge
        hs(4'h6);
        hs(4'h7);
        data_driver = 4'h8;
        cur_word    = 4'h8;
        data_req    = 1'b1;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("simul_ack", data_ack, 1);
        check("simul_cnt", fifo_cnt, 2);
        data_req = 1'b0;
        wait_ack(1'b0, 10);
        drain();

        // Continuous drain across pointer wrap
        max_cnt   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) hs(4'(i));
        tick();
        out_ready = 1'b0;
        check("wrap_max_le1", max_cnt <= 1, 1);
        check("wrap_end_cnt", fifo_cnt, 0);

        // Asynchronous reset while in ACK with three words stored
        hs(4'h1);
        hs(4'h2);
        data_driver = 4'h3;
        cur_word    = 4'h3;
        data_req    = 1'b1;
        wait_ack(1'b1, 10);
        check("pre_rst_cnt", fifo_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ack", data_ack, 0);
        check("arst_valid", out_valid, 0);
        check("arst_cnt", fifo_cnt, 0);
        check("arst_xfer", xfer_cnt, 0);
        q.delete();
        xfer_m = 8'd0;
        #2;
        rst_n = 1'b1;
        wait_ack(1'b1, 10);
        check("post_rst_cnt", fifo_cnt, 1);
        check("post_rst_xfer", xfer_cnt, 1);
        data_req = 1'b0;
        wait_ack(1'b0, 10);
        drain();

        // Random words and consumer stalls, long enough to wrap xfer_cnt
        rnd = 1'b1;
        for (int i = 0; i < 270; i++) begin
            hs(4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        rnd = 1'b0;
        check("rand_xfer_wrap", xfer_cnt, xfer_m);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
